// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants and monitor state type
package seg7_pkg;

    // Active-low segment patterns for hex digits 0..F (bit7 = dp, shown off).
    // The display driver encodes from this same table.
    localparam logic [15:0][7:0] SEG_DIGITS = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] SEL_NONE  = 8'hFF;

    typedef enum logic {
        SETTLE  = 1'b0,
        LATCHED = 1'b1
    } mon_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to hex nibble decoder
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        blank  = 1'b0;
        nibble = 4'h0;
        if (pattern == SEG_BLANK) begin
            hit   = 1'b1;
            blank = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (pattern == SEG_DIGITS[i][6:0]) begin
                    hit    = 1'b1;
                    nibble = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/seg7_scan_monitor.sv
// rtl/seg7_scan_monitor.sv - samples a scanned 7-segment bus and rebuilds the 8-digit value
module seg7_scan_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_seg,
    input  logic [7:0]  i_sel,
    output logic [31:0] o_value,
    output logic [7:0]  o_dp,
    output logic [7:0]  o_blank,
    output logic        o_valid,
    output logic        o_err
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    mon_state_t  state, state_n;
    logic [15:0] prev;
    logic [7:0]  cnt;
    logic        changed, eval;

    logic        sel_none, sel_onehot;
    logic [2:0]  idx;
    logic        pat_hit, pat_blank;
    logic [3:0]  pat_nib;
    logic        capture, bad, frame_done;

    logic [31:0] sh_value, sh_value_n;
    logic [7:0]  sh_dp, sh_dp_n, sh_blank, sh_blank_n;
    logic [7:0]  seen, seen_n;

    assign changed = ({i_sel, i_seg} != prev);

    always_comb begin
        state_n = state;
        eval    = 1'b0;
        case (state)
            SETTLE: begin
                if (!changed && cnt == CNT_MAX) begin
                    eval    = 1'b1;
                    state_n = LATCHED;
                end
            end
            LATCHED: begin
                if (changed) state_n = SETTLE;
            end
            default: state_n = SETTLE;
        endcase
    end

    assign sel_none   = (i_sel == SEL_NONE);
    assign sel_onehot = $onehot(~i_sel);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!i_sel[i]) idx = 3'(i);
        end
    end

    seg7_pattern_decode u_decode (
        .pattern (i_seg[6:0]),
        .hit     (pat_hit),
        .blank   (pat_blank),
        .nibble  (pat_nib)
    );

    // An all-off select is a legitimate scan gap, so it is neither captured nor flagged.
    assign capture = eval && sel_onehot && pat_hit;
    assign bad     = eval && !sel_none && !(sel_onehot && pat_hit);

    always_comb begin
        sh_value_n = sh_value;
        sh_dp_n    = sh_dp;
        sh_blank_n = sh_blank;
        seen_n     = seen;
        if (capture) begin
            sh_value_n[idx*4 +: 4] = pat_nib;
            sh_dp_n[idx]           = ~i_seg[7];
            sh_blank_n[idx]        = pat_blank;
            seen_n[idx]            = 1'b1;
        end
    end

    assign frame_done = capture && (seen_n == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SETTLE;
            prev     <= 16'hFFFF;
            cnt      <= 8'd0;
            seen     <= 8'd0;
            sh_value <= 32'd0;
            sh_dp    <= 8'd0;
            sh_blank <= 8'd0;
            o_value  <= 32'd0;
            o_dp     <= 8'd0;
            o_blank  <= 8'd0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_n;
            prev     <= {i_sel, i_seg};
            if (changed)             cnt <= 8'd0;
            else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
            sh_value <= sh_value_n;
            sh_dp    <= sh_dp_n;
            sh_blank <= sh_blank_n;
            seen     <= frame_done ? 8'd0 : seen_n;
            if (frame_done) begin
                o_value <= sh_value_n;
                o_dp    <= sh_dp_n;
                o_blank <= sh_blank_n;
            end
            o_valid  <= frame_done;
            o_err    <= bad;
        end
    end

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// tb/tb_seg7_scan_monitor.sv - randomized and directed bench for seg7_scan_monitor
module tb_seg7_scan_monitor;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  i_seg = 8'hFF;
    logic [7:0]  i_sel = 8'hFF;
    logic [31:0] o_value;
    logic [7:0]  o_dp, o_blank;
    logic        o_valid, o_err;

    seg7_scan_monitor #(.STABLE_CYCLES(STABLE)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_seg   (i_seg),
        .i_sel   (i_sel),
        .o_value (o_value),
        .o_dp    (o_dp),
        .o_blank (o_blank),
        .o_valid (o_valid),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;

    bit [7:0] pat_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // reference model: per-digit shadow, seen set, published frame, expected pulses
    bit [31:0] m_val;
    bit [7:0]  m_dp, m_blk, m_seen;
    bit [31:0] exp_value;
    bit [7:0]  exp_dp, exp_blank;
    bit        exp_valid, exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lookup(input bit [6:0] p);
        for (int i = 0; i < 16; i++)
            if (pat_tab[i][6:0] == p) return i;
        if (p == 7'h7F) return 16;
        return -1;
    endfunction

    task automatic model_clear();
        m_val = 0; m_dp = 0; m_blk = 0; m_seen = 0;
        exp_value = 0; exp_dp = 0; exp_blank = 0; exp_valid = 0; exp_err = 0;
    endtask

    task automatic model_eval(input bit [7:0] sel, input bit [7:0] seg);
        int k;
        int code;
        if (sel == 8'hFF) return;
        if ($countones(~sel) != 1) begin
            exp_err = 1;
            return;
        end
        k = 0;
        for (int i = 0; i < 8; i++) if (!sel[i]) k = i;
        code = lookup(seg[6:0]);
        if (code < 0) begin
            exp_err = 1;
            return;
        end
        m_val[k*4 +: 4] = (code == 16) ? 4'h0 : 4'(code);
        m_dp[k]   = ~seg[7];
        m_blk[k]  = (code == 16);
        m_seen[k] = 1'b1;
        if (m_seen == 8'hFF) begin
            exp_value = m_val;
            exp_dp    = m_dp;
            exp_blank = m_blk;
            exp_valid = 1;
            m_seen    = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_valid"}, o_valid, exp_valid);
        check({tag, "_err"}, o_err, exp_err);
        check({tag, "_value"}, o_value, exp_value);
        check({tag, "_dp"}, o_dp, exp_dp);
        check({tag, "_blank"}, o_blank, exp_blank);
        if (o_valid) n_valid++;
        if (o_err) n_err++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            model_clear();
            compare_all("reset");
        end
        reset = 1'b0;
    endtask

    // Hold one bus value for len cycles; it is evaluated on the edge closing cycle STABLE.
    task automatic hold(input bit [7:0] sel, input bit [7:0] seg, input int len);
        i_sel = sel;
        i_seg = seg;
        for (int j = 0; j < len; j++) begin
            @(posedge clk); #1;
            exp_valid = 0;
            exp_err   = 0;
            if (j == STABLE) model_eval(sel, seg);
            compare_all("hold");
        end
    endtask

    task automatic scan(input bit [31:0] val, input int dwell);
        for (int k = 0; k < 8; k++)
            hold(~(8'h01 << k), pat_tab[val[k*4 +: 4]], dwell);
    endtask

    initial begin
        int v0, e0;
        bit [15:0] last;
        bit [7:0] rs, rg;
        int r;

        do_reset(2);

        v0 = n_valid;
        scan(32'h12345678, 10);
        scan(32'h12345678, 10);
        check("two_rotations_valids", n_valid - v0, 2);
        check("two_rotations_value", o_value, 32'h12345678);

        e0 = n_err; v0 = n_valid;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                hold(8'hFB, pat_tab[6], 6);
                hold(8'hFB, 8'h80, 3);
                hold(8'hFB, pat_tab[6], 6);
            end else begin
                hold(~(8'h01 << k), pat_tab[8 - k], 10);
            end
        end
        check("glitch_no_err", n_err - e0, 0);
        check("glitch_frame", n_valid - v0, 1);
        check("glitch_value", o_value, 32'h12345678);

        e0 = n_err;
        hold(8'hF3, 8'hC0, 10);
        check("illegal_sel_err", n_err - e0, 1);
        e0 = n_err;
        hold(8'hFF, 8'hC0, 10);
        check("sel_none_no_err", n_err - e0, 0);

        e0 = n_err; v0 = n_valid;
        for (int k = 1; k < 8; k++) hold(~(8'h01 << k), pat_tab[8 - k], 10);
        hold(8'hFE, 8'hF7, 10);
        check("bad_pattern_err", n_err - e0, 1);
        check("bad_pattern_no_frame", n_valid - v0, 0);
        hold(8'hFE, pat_tab[8], 10);
        check("bad_pattern_then_frame", n_valid - v0, 1);
        check("bad_pattern_value", o_value, 32'h12345678);

        for (int k = 0; k < 8; k++)
            hold(~(8'h01 << k), (k == 3) ? 8'h7F : pat_tab[k + 1], 10);
        check("blank_digit_value", o_value, 32'h87650321);
        check("blank_digit_blank", o_blank, 8'h08);
        check("blank_digit_dp", o_dp, 8'h08);

        for (int k = 0; k < 5; k++) hold(~(8'h01 << k), pat_tab[1], 10);
        do_reset(1);
        v0 = n_valid;
        scan(32'hDEADBEEF, 10);
        check("after_reset_valids", n_valid - v0, 1);
        check("after_reset_value", o_value, 32'hDEADBEEF);

        last = {i_sel, i_seg};
        for (int h = 0; h < 400; h++) begin
            do begin
                r = $urandom_range(0, 9);
                if (r == 0)      rs = 8'hFF;
                else if (r == 1) rs = 8'($urandom);
                else             rs = ~(8'h01 << $urandom_range(0, 7));
                r = $urandom_range(0, 19);
                if (r < 17)      rg = pat_tab[$urandom_range(0, 15)];
                else if (r < 19) rg = 8'hFF;
                else             rg = 8'($urandom);
                if ($urandom_range(0, 3) == 0) rg[7] = 1'b0;
            end while ({rs, rg} == last);
            last = {rs, rg};
            hold(rs, rg, $urandom_range(1, 12));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
